// File: rtl/fifo_read_streamer.sv
// Drains a synchronous FIFO into a valid/ready stream. A 2-entry skid buffer absorbs the
// FIFO's one-cycle read latency so reads and pops can both run every cycle.
module fifo_read_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  underflow_err
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;

  logic       pop, capture;
  logic [2:0] credit_used, occ_sum;
  logic [1:0] wr_idx;

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf0_q;
  assign word_cnt      = cnt_q;
  assign underflow_err = err_q;

  assign pop     = m_valid & m_ready;
  assign capture = inflight_q & ~fifo_underflow;

  // Slots already promised: buffered + returning next edge, minus the one leaving now.
  assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en  = ~rst & enable & ~fifo_empty & (credit_used < 3'd2);

  assign occ_sum = {1'b0, occ_q} - {2'b00, pop} + {2'b00, capture};
  assign wr_idx  = occ_q - {1'b0, pop};

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_sum[1:0];
    if (pop && occ_q == 2'd2) buf0_d = buf1_q;
    // Capture lands behind whatever survives this cycle's pop.
    if (capture) begin
      if (wr_idx == 2'd0) buf0_d = fifo_data_out;
      else                buf1_d = fifo_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      if (pop) cnt_q <= cnt_q + CNT_WIDTH'(1);
      err_q      <= err_q | fifo_underflow;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (occ_sum <= 3'd2);
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a hand-derived vector table, then a queue-based FIFO and
// stream model driving directed and random traffic into two instances (16- and 4-bit counters).
module tb_fifo_read_streamer;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, fifo_underflow, m_ready;
  logic [15:0] fifo_data_out;
  logic        fifo_rd_en, m_valid, underflow_err;
  logic [15:0] m_data, word_cnt;
  logic        fifo_rd_en4, m_valid4, underflow_err4;
  logic [15:0] m_data4;
  logic [3:0]  word_cnt4;

  always #5 clk = ~clk;

  fifo_read_streamer #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .word_cnt(word_cnt),
    .underflow_err(underflow_err));

  fifo_read_streamer #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en4),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready), .word_cnt(word_cnt4),
    .underflow_err(underflow_err4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, en, empty, uf, rdy;
    logic [15:0] data;
    logic        e_rden, e_valid;
    logic [15:0] e_data;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[15];

  // Reference model state
  logic [15:0] fmem[$];
  logic [15:0] exp_q[$];
  logic [15:0] f_data = '0;
  logic        f_uf = 1'b0;
  int m_inflight, pops, exp_err;
  int rd_cnt, pop_cnt, rd_run, rd_run_max, pop_run, pop_run_max, pushed;

  task automatic clear_stats();
    rd_cnt = 0; pop_cnt = 0; rd_run = 0; rd_run_max = 0; pop_run = 0; pop_run_max = 0;
  endtask

  task automatic mcycle();
    int held, pop_i, exp_rd;
    fifo_empty     = (fmem.size() == 0);
    fifo_data_out  = f_data;
    fifo_underflow = f_uf;
    #1;
    if (rst) begin
      chk("rst_rden", {31'b0, fifo_rd_en}, 0);
      exp_q.delete();
      m_inflight = 0; pops = 0; exp_err = 0; pop_run = 0; rd_run = 0;
    end else begin
      held = exp_q.size();
      chk("valid", {31'b0, m_valid}, (held > 0) ? 1 : 0);
      if (held > 0) chk("data", {16'b0, m_data}, {16'b0, exp_q[0]});
      pop_i  = (held > 0 && m_ready) ? 1 : 0;
      exp_rd = (enable && !fifo_empty && (held + m_inflight - pop_i < 2)) ? 1 : 0;
      chk("rden", {31'b0, fifo_rd_en}, exp_rd);
      chk("cnt", {16'b0, word_cnt}, {16'b0, pops[15:0]});
      chk("cnt4", {28'b0, word_cnt4}, {28'b0, pops[3:0]});
      chk("err", {31'b0, underflow_err}, exp_err);
      if (pop_i == 1) begin
        void'(exp_q.pop_front());
        pops++; pop_cnt++; pop_run++;
        if (pop_run > pop_run_max) pop_run_max = pop_run;
      end else pop_run = 0;
      if (m_inflight == 1 && !fifo_underflow) exp_q.push_back(fifo_data_out);
      if (fifo_underflow) exp_err = 1;
      m_inflight = fifo_rd_en ? 1 : 0;
      if (fifo_rd_en) begin
        rd_cnt++; rd_run++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
      end else rd_run = 0;
    end
    // FIFO read port: data registered one cycle after rd_en
    f_uf = 1'b0;
    if (fifo_rd_en) begin
      if (fmem.size() > 0) f_data = fmem.pop_front();
      else f_uf = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) mcycle();
    rst = 1'b0;
    f_uf = 1'b0;
    clear_stats();
    chk("rst_data", {16'b0, m_data}, 0);
    chk("rst_valid", {31'b0, m_valid}, 0);
    chk("rst_cnt", {16'b0, word_cnt}, 0);
    chk("rst_err", {31'b0, underflow_err}, 0);
  endtask

  task automatic load(input int n, input int base);
    fmem.delete();
    for (int i = 0; i < n; i++) fmem.push_back(16'(base + i));
  endtask

  initial begin
    //            rst en emp uf rdy data      rden vld data     err cnt
    tbl[0]  = '{1, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'd0};
    tbl[1]  = '{1, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'd0};
    tbl[2]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'd0};
    tbl[3]  = '{0, 1, 0, 0, 0, 16'h00A1, 1, 0, 16'h0000, 0, 16'd0};
    tbl[4]  = '{0, 1, 0, 0, 0, 16'h00A2, 0, 1, 16'h00A1, 0, 16'd0};
    tbl[5]  = '{0, 1, 0, 0, 0, 16'h00A3, 0, 1, 16'h00A1, 0, 16'd0};
    tbl[6]  = '{0, 1, 0, 0, 1, 16'h00A3, 1, 1, 16'h00A1, 0, 16'd0};
    tbl[7]  = '{0, 1, 0, 1, 0, 16'h00A3, 0, 1, 16'h00A2, 0, 16'd1};
    tbl[8]  = '{0, 1, 0, 0, 0, 16'h00A3, 1, 1, 16'h00A2, 1, 16'd1};
    tbl[9]  = '{0, 0, 0, 0, 1, 16'h00A4, 0, 1, 16'h00A2, 1, 16'd1};
    tbl[10] = '{0, 0, 0, 0, 1, 16'h00A4, 0, 1, 16'h00A4, 1, 16'd2};
    tbl[11] = '{0, 0, 0, 0, 1, 16'h00A4, 0, 0, 16'h00A4, 1, 16'd3};
    tbl[12] = '{0, 1, 1, 0, 1, 16'h00A4, 0, 0, 16'h00A4, 1, 16'd3};
    tbl[13] = '{1, 1, 1, 0, 1, 16'h00A4, 0, 0, 16'h00A4, 1, 16'd3};
    tbl[14] = '{0, 1, 1, 0, 1, 16'h00A4, 0, 0, 16'h0000, 0, 16'd0};

    rst = 1'b1; enable = 1'b1; fifo_empty = 1'b0; fifo_underflow = 1'b0;
    m_ready = 1'b0; fifo_data_out = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; fifo_empty = tbl[i].empty;
      fifo_underflow = tbl[i].uf; m_ready = tbl[i].rdy; fifo_data_out = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d_rden", i), {31'b0, fifo_rd_en}, {31'b0, tbl[i].e_rden});
      chk($sformatf("tbl%0d_valid", i), {31'b0, m_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_data", i), {16'b0, m_data}, {16'b0, tbl[i].e_data});
      chk($sformatf("tbl%0d_err", i), {31'b0, underflow_err}, {31'b0, tbl[i].e_err});
      chk($sformatf("tbl%0d_cnt", i), {16'b0, word_cnt}, {16'b0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_cnt4", i), {28'b0, word_cnt4}, {28'b0, tbl[i].e_cnt[3:0]});
      @(posedge clk); #1;
    end

    // Streaming: FIFO holds data across reset, then full-rate drain
    load(8, 1); enable = 1'b1; m_ready = 1'b1;
    do_reset();
    repeat (14) mcycle();
    chk("stream_rd_run", rd_run_max, 8);
    chk("stream_pop_run", pop_run_max, 8);
    chk("stream_cnt", {16'b0, word_cnt}, 8);

    // Backpressure: only two reads while stalled, head held
    load(8, 1); m_ready = 1'b0;
    do_reset();
    repeat (10) mcycle();
    chk("bp_reads", rd_cnt, 2);
    chk("bp_head", {16'b0, m_data}, 16'h0001);
    m_ready = 1'b1; pop_run_max = 0;
    repeat (12) mcycle();
    chk("bp_pop_run", pop_run_max, 8);
    chk("bp_total", pop_cnt, 8);

    // Alternating ready
    load(20, 16'h0100); m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      m_ready = i[0];
      mcycle();
    end
    chk("alt_total", pop_cnt, 20);

    // Enable dropped one cycle after the first read
    load(4, 16'h0200); m_ready = 1'b1; enable = 1'b1;
    do_reset();
    mcycle();
    enable = 1'b0;
    repeat (8) mcycle();
    chk("en_reads", rd_cnt, 1);
    chk("en_pops", pop_cnt, 1);
    enable = 1'b1;
    repeat (10) mcycle();
    chk("en_resume", pop_cnt, 4);

    // Single word in FIFO
    load(1, 16'h0055);
    do_reset();
    repeat (8) mcycle();
    chk("one_reads", rd_cnt, 1);
    chk("one_pops", pop_cnt, 1);

    // Counter wrap on the 4-bit instance
    load(17, 16'h0300);
    do_reset();
    repeat (25) mcycle();
    chk("wrap_cnt4", {28'b0, word_cnt4}, 1);
    chk("wrap_cnt", {16'b0, word_cnt}, 17);

    // Random traffic
    fmem.delete(); pushed = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0 && fmem.size() < 16) begin
        fmem.push_back(16'($urandom));
        pushed++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      mcycle();
    end
    enable = 1'b1; m_ready = 1'b1;
    repeat (40) mcycle();
    chk("rand_total", pop_cnt, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
